// File: rtl/multi_pwm_pkg.sv
// Shared constants, FSM state type and the duty slew helper for the multi-channel PWM.
package multi_pwm_pkg;

    localparam int NUM_CH_DEF   = 4;
    localparam int CNT_BITS_DEF = 7;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Signed distance is taken in full int width, so act +/- step never leaves the duty range.
    function automatic int slew_step(input int shadow, input int act, input int step);
        int diff;
        diff = shadow - act;
        if (step <= 0) begin
            return shadow;
        end
        if (diff > step) begin
            return act + step;
        end
        if (diff < -step) begin
            return act - step;
        end
        return shadow;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active duty pair with slew-limited boundary load and a registered compare.
module pwm_channel
    import multi_pwm_pkg::*;
#(
    parameter int CNT_BITS = CNT_BITS_DEF,
    parameter int STEP_MAX = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CNT_BITS-1:0] cnt_next_i,
    input  logic                load_i,
    input  logic                run_next_i,
    input  logic                wr_i,
    input  logic [CNT_BITS-1:0] din_i,
    output logic                pwm_o,
    output logic [CNT_BITS-1:0] act_o
);

    logic [CNT_BITS-1:0] shadow_q, shadow_d;
    logic [CNT_BITS-1:0] act_q, act_d;
    logic                pwm_q, pwm_d;

    // The load reads shadow_d so a write on the boundary edge takes effect immediately.
    always_comb begin
        shadow_d = wr_i ? din_i : shadow_q;
        act_d    = act_q;
        if (!run_next_i) begin
            act_d = '0;
        end else if (load_i) begin
            act_d = CNT_BITS'(slew_step(int'(shadow_d), int'(act_q), STEP_MAX));
        end
        pwm_d = run_next_i && (cnt_next_i < act_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q <= '0;
            act_q    <= '0;
            pwm_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            act_q    <= act_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;
    assign act_o = act_q;

endmodule

// File: rtl/multi_pwm.sv
// Multi-channel motor PWM: shared free-running period counter, arm/disarm FSM and period_start pulse.
module multi_pwm
    import multi_pwm_pkg::*;
#(
    parameter int NUM_CH   = NUM_CH_DEF,
    parameter int CNT_BITS = CNT_BITS_DEF,
    parameter int STEP_MAX = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         arm,
    input  logic [NUM_CH-1:0]            duty_wr,
    input  logic [NUM_CH*CNT_BITS-1:0]   duty_in,
    output logic [NUM_CH-1:0]            pwm_out,
    output logic                         period_start,
    output logic [NUM_CH*CNT_BITS-1:0]   act_duty
);

    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

    state_e              state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                ps_q, ps_d;
    logic                load;
    logic                run_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ps_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ps_q    <= ps_d;
        end
    end

    // Arming edge and counter wrap are both period boundaries; disarm clears everything at once.
    always_comb begin
        state_d = arm ? RUN : IDLE;
        cnt_d   = '0;
        load    = 1'b0;
        if (arm) begin
            if ((state_q == IDLE) || (cnt_q == CNT_MAX)) begin
                load = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
        ps_d     = load;
        run_next = (state_d == RUN);
    end

    assign period_start = ps_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        pwm_channel #(
            .CNT_BITS (CNT_BITS),
            .STEP_MAX (STEP_MAX)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .cnt_next_i (cnt_d),
            .load_i     (load),
            .run_next_i (run_next),
            .wr_i       (duty_wr[c]),
            .din_i      (duty_in[c*CNT_BITS +: CNT_BITS]),
            .pwm_o      (pwm_out[c]),
            .act_o      (act_duty[c*CNT_BITS +: CNT_BITS])
        );
    end

endmodule
